// File: rtl/moment_bank_if.sv
// Request/response bundle for moment_bank_ram. Channel k of every data word
// sits at [k*DW +: DW], the same layout as a flat NUM_CH*DW vector.
interface moment_bank_if #(
   parameter int AW     = 8,
   parameter int DW     = 32,
   parameter int NUM_CH = 3
);
   logic                           clear_req;
   logic                           busy;
   logic                           rd_en;
   logic [AW-1:0]                  rd_addr;
   logic [NUM_CH-1:0][DW-1:0]      rd_data;
   logic                           rd_valid;
   logic                           wr_en;
   logic                           wr_mode;
   logic [AW-1:0]                  wr_addr;
   logic [NUM_CH-1:0]              wr_mask;
   logic [NUM_CH-1:0][DW-1:0]      wr_data;
   logic [NUM_CH-1:0]              ovf;

   modport master (
      output clear_req, rd_en, rd_addr, wr_en, wr_mode, wr_addr, wr_mask, wr_data,
      input  busy, rd_data, rd_valid, ovf
   );

   modport slave (
      input  clear_req, rd_en, rd_addr, wr_en, wr_mode, wr_addr, wr_mask, wr_data,
      output busy, rd_data, rd_valid, ovf
   );
endinterface

// File: rtl/moment_bank_ram.sv
// Multi-channel LBM moment store: registered reads, masked overwrite or
// saturating accumulate through a one-deep forwarding write stage, and a zero sweep.
module moment_lane #(
   parameter int DW = 32
) (
   input  logic [DW-1:0] old,
   input  logic [DW-1:0] opnd,
   input  logic          en,
   input  logic          acc,
   output logic [DW-1:0] res,
   output logic          sat
);
   logic [DW:0] sum;
   logic        ovr;

   // sign-extended DW+1 sum; top two bits disagree exactly on overflow
   assign sum = {old[DW-1], old} + {opnd[DW-1], opnd};
   assign ovr = sum[DW] ^ sum[DW-1];

   always_comb begin
      res = old;
      sat = 1'b0;
      if (en) begin
         if (!acc) begin
            res = opnd;
         end else if (ovr) begin
            sat = 1'b1;
            res = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
         end else begin
            res = sum[DW-1:0];
         end
      end
   end
endmodule

module moment_bank_ram #(
   parameter int DEPTH         = 16*16,
   parameter int ADDRESS_WIDTH = $clog2(DEPTH),
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_CH        = 3
) (
   input  logic          Clk,
   input  logic          Reset_n,
   moment_bank_if.slave  bus
);
   typedef logic [NUM_CH-1:0][DATA_WIDTH-1:0] word_t;
   typedef enum logic {CLEAR, IDLE} state_t;

   typedef struct packed {
      logic                     vld;
      logic [ADDRESS_WIDTH-1:0] addr;
      word_t                    res;
   } stage_t;

   state_t                   state, state_nx;
   logic [ADDRESS_WIDTH-1:0] clr_cnt;
   logic                     clr_last;
   word_t                    mem [DEPTH];
   stage_t                   st;

   logic                     idle, clr_acc, wr_acc, rd_acc;
   word_t                    wr_old, wr_res, rd_view;
   logic [NUM_CH-1:0]        wr_sat;

   logic                     rd_valid_q;
   word_t                    rd_data_q;
   logic [NUM_CH-1:0]        ovf_q;

   assign idle     = (state == IDLE);
   assign clr_acc  = idle & bus.clear_req;
   assign wr_acc   = idle & ~bus.clear_req & bus.wr_en;
   assign rd_acc   = idle & ~bus.clear_req & bus.rd_en;
   assign clr_last = (clr_cnt == ADDRESS_WIDTH'(DEPTH-1));

   // the stage holds the newest value of its node until it commits next edge
   assign wr_old  = (st.vld && st.addr == bus.wr_addr) ? st.res : mem[bus.wr_addr];
   assign rd_view = (st.vld && st.addr == bus.rd_addr) ? st.res : mem[bus.rd_addr];

   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      moment_lane #(.DW(DATA_WIDTH)) u_lane (
         .old  (wr_old[k]),
         .opnd (bus.wr_data[k]),
         .en   (bus.wr_mask[k]),
         .acc  (bus.wr_mode),
         .res  (wr_res[k]),
         .sat  (wr_sat[k])
      );
   end

   always_comb begin
      state_nx = state;
      case (state)
         CLEAR:   if (clr_last) state_nx = IDLE;
         IDLE:    if (bus.clear_req) state_nx = CLEAR;
         default: state_nx = CLEAR;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= CLEAR;
         clr_cnt    <= '0;
         st         <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         ovf_q      <= '0;
      end else begin
         state      <= state_nx;
         clr_cnt    <= (state == CLEAR && !clr_last) ? clr_cnt + 1'b1 : '0;
         st.vld     <= wr_acc;
         if (wr_acc) begin
            st.addr <= bus.wr_addr;
            st.res  <= wr_res;
         end
         rd_valid_q <= rd_acc;
         if (rd_acc) rd_data_q <= rd_view;
         if (clr_acc)     ovf_q <= '0;
         else if (wr_acc) ovf_q <= ovf_q | wr_sat;
      end
   end

   // array is never reset; the sweep is what zeroes it
   always_ff @(posedge Clk) begin
      if (state == CLEAR)
         mem[clr_cnt] <= '0;
      else if (st.vld && !clr_acc)
         mem[st.addr] <= st.res;
   end

   assign bus.busy     = (state == CLEAR);
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_moment_bank_ram.sv
// Bench for moment_bank_ram: vector table plus hand sequences for clear and reset;
// read results are checked against a queue of expected words.
module tb_moment_bank_ram;
   localparam int DEPTH = 256;
   localparam int AW    = 8;
   localparam int DW    = 32;
   localparam int NC    = 3;

   typedef logic [NC-1:0][DW-1:0] word_t;

   typedef struct {
      string        nm;
      logic         we;
      logic         mode;
      logic [AW-1:0] wa;
      logic [NC-1:0] m;
      word_t        d;
      logic         re;
      logic [AW-1:0] ra;
      word_t        e;
      logic [NC-1:0] eovf;
   } vec_t;

   logic Clk = 1'b0;
   logic Reset_n = 1'b0;
   always #5 Clk = ~Clk;

   moment_bank_if #(.AW(AW), .DW(DW), .NUM_CH(NC)) bus ();

   moment_bank_ram #(
      .DEPTH(DEPTH), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NC)
   ) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   int    nvec = 0;
   int    nmis = 0;
   word_t scb[$];
   vec_t  vt[21];

   function automatic word_t w3(input int c2, input int c1, input int c0);
      return {c2, c1, c0};
   endfunction

   function automatic vec_t mk(input string nm, input logic we, input logic mode,
                               input int wa, input logic [NC-1:0] m, input word_t d,
                               input logic re, input int ra, input word_t e,
                               input logic [NC-1:0] eovf);
      vec_t v;
      v.nm = nm; v.we = we; v.mode = mode; v.wa = AW'(wa); v.m = m; v.d = d;
      v.re = re; v.ra = AW'(ra); v.e = e; v.eovf = eovf;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic we, input logic mode, input int wa, input logic [NC-1:0] m,
                      input word_t d, input logic re, input int ra, input logic clr);
      bus.wr_en = we; bus.wr_mode = mode; bus.wr_addr = AW'(wa); bus.wr_mask = m;
      bus.wr_data = d; bus.rd_en = re; bus.rd_addr = AW'(ra); bus.clear_req = clr;
      @(posedge Clk);
      #1;
      bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.clear_req = 1'b0;
   endtask

   task automatic wait_sweep(input string nm);
      int n = 0;
      for (int t = 0; t < 1000 && bus.busy; t++) begin
         n++;
         @(negedge Clk);
      end
      chk(nm, n, DEPTH);
   endtask

   // read scoreboard: every rd_valid cycle must match the oldest outstanding expectation
   always @(negedge Clk) begin
      if (Reset_n && bus.rd_valid) begin
         nvec++;
         if (scb.size() == 0) begin
            nmis++;
            $display("FAIL rd_unexpected: rd_valid=1 with nothing outstanding, data %h", bus.rd_data);
         end else begin
            word_t e;
            e = scb.pop_front();
            if (bus.rd_data !== e) begin
               nmis++;
               $display("FAIL rd_data: got %h expected %h", bus.rd_data, e);
            end
         end
      end
   end

   initial begin
      int n;
      bus.clear_req = 0; bus.rd_en = 0; bus.rd_addr = '0; bus.wr_en = 0;
      bus.wr_mode = 0; bus.wr_addr = '0; bus.wr_mask = '0; bus.wr_data = '0;

      vt[0]  = mk("rd0_zero",   0,0,0,  3'b000, '0,                     1,0,  '0,                     3'b000);
      vt[1]  = mk("rd255_zero", 0,0,0,  3'b000, '0,                     1,255,'0,                     3'b000);
      vt[2]  = mk("ow5_mask",   1,0,5,  3'b101, w3(7,9,-3),             0,0,  '0,                     3'b000);
      vt[3]  = mk("rd5",        0,0,0,  3'b000, '0,                     1,5,  w3(7,0,-3),             3'b000);
      vt[4]  = mk("acc10_a",    1,1,10, 3'b111, w3(1,2,-1),             0,0,  '0,                     3'b000);
      vt[5]  = mk("acc10_b",    1,1,10, 3'b111, w3(1,2,-1),             0,0,  '0,                     3'b000);
      vt[6]  = mk("acc10_c",    1,1,10, 3'b111, w3(1,2,-1),             0,0,  '0,                     3'b000);
      vt[7]  = mk("acc10_d",    1,1,10, 3'b111, w3(1,2,-1),             0,0,  '0,                     3'b000);
      vt[8]  = mk("rd10_ow20",  1,0,20, 3'b010, w3(0,123,0),            1,10, w3(4,8,-4),             3'b000);
      vt[9]  = mk("rd20_ow0",   1,0,0,  3'b001, w3(0,0,32'h7FFFFFF0),   1,20, w3(0,123,0),            3'b000);
      vt[10] = mk("acc0_satp",  1,1,0,  3'b001, w3(0,0,32'h20),         0,0,  '0,                     3'b001);
      vt[11] = mk("rd0_max",    0,0,0,  3'b000, '0,                     1,0,  w3(0,0,32'h7FFFFFFF),   3'b001);
      vt[12] = mk("ow3_rd3_old",1,0,3,  3'b111, w3(42,42,42),           1,3,  '0,                     3'b001);
      vt[13] = mk("rd3_new",    0,0,0,  3'b000, '0,                     1,3,  w3(42,42,42),           3'b001);
      vt[14] = mk("ow1_ch1",    1,0,1,  3'b010, w3(0,32'h80000010,0),   0,0,  '0,                     3'b001);
      vt[15] = mk("acc1_satn",  1,1,1,  3'b010, w3(0,-32,0),            0,0,  '0,                     3'b011);
      vt[16] = mk("rd1_min",    0,0,0,  3'b000, '0,                     1,1,  w3(0,32'h80000000,0),   3'b011);
      vt[17] = mk("acc1_sticky",1,1,1,  3'b010, w3(0,5,0),              1,1,  w3(0,32'h80000000,0),   3'b011);
      vt[18] = mk("rd1_fwd",    0,0,0,  3'b000, '0,                     1,1,  w3(0,32'h80000005,0),   3'b011);
      vt[19] = mk("acc5_ch2",   1,1,5,  3'b100, w3(-10,999,0),          1,5,  w3(7,0,-3),             3'b011);
      vt[20] = mk("rd5_acc",    0,0,0,  3'b000, '0,                     1,5,  w3(-3,0,-3),            3'b011);

      // reset values while Reset_n is held low
      #12;
      chk("rst_busy", bus.busy, 1'b1);
      chk("rst_rd_valid", bus.rd_valid, 1'b0);
      chk("rst_rd_data", bus.rd_data, '0);
      chk("rst_ovf", bus.ovf, '0);

      @(negedge Clk);
      Reset_n = 1'b1;
      wait_sweep("busy_after_reset");

      foreach (vt[i]) begin
         if (vt[i].re) scb.push_back(vt[i].e);
         cyc(vt[i].we, vt[i].mode, int'(vt[i].wa), vt[i].m, vt[i].d, vt[i].re, int'(vt[i].ra), 1'b0);
         chk({"ovf_", vt[i].nm}, bus.ovf, vt[i].eovf);
      end

      // clear request drops the concurrent write and read, clears ovf
      cyc(1, 0, 7, 3'b111, w3(99,99,99), 1, 7, 1);
      chk("clr_ovf", bus.ovf, '0);
      n = 0;
      for (int t = 0; t < 1000 && bus.busy; t++) begin
         n++;
         cyc(0, 0, 0, 3'b000, '0, t == 5, 3, 0);
         if (t == 5) chk("rd_valid_busy", bus.rd_valid, 1'b0);
      end
      chk("busy_after_clear", n, DEPTH);
      scb.push_back('0); cyc(0,0,0,3'b000,'0, 1, 7, 0);
      scb.push_back('0); cyc(0,0,0,3'b000,'0, 1, 0, 0);
      scb.push_back('0); cyc(0,0,0,3'b000,'0, 1, 5, 0);
      scb.push_back('0); cyc(0,0,0,3'b000,'0, 1, 1, 0);
      cyc(0,0,0,3'b000,'0, 0, 0, 0);
      chk("ovf_after_sweep", bus.ovf, '0);

      // reset mid-operation with a read result, ovf and a stage op all live
      cyc(1, 0, 2, 3'b100, w3(32'h7FFFFFFF,0,0), 0, 0, 0);
      cyc(1, 1, 2, 3'b100, w3(1,0,0), 1, 2, 0);
      chk("pre_rst_rd_valid", bus.rd_valid, 1'b1);
      chk("pre_rst_rd_data", bus.rd_data, w3(32'h7FFFFFFF,0,0));
      chk("pre_rst_ovf", bus.ovf, 3'b100);
      Reset_n = 1'b0;
      #1;
      chk("mid_rst_busy", bus.busy, 1'b1);
      chk("mid_rst_rd_valid", bus.rd_valid, 1'b0);
      chk("mid_rst_rd_data", bus.rd_data, '0);
      chk("mid_rst_ovf", bus.ovf, '0);
      @(negedge Clk);
      Reset_n = 1'b1;
      wait_sweep("busy_after_rerst");
      scb.push_back('0); cyc(0,0,0,3'b000,'0, 1, 2, 0);
      cyc(0,0,0,3'b000,'0, 0, 0, 0);
      cyc(0,0,0,3'b000,'0, 0, 0, 0);
      chk("scb_drained", scb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
